// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI register-bank arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSpiWr = 2'd1,
    StLcl   = 2'd2
  } arb_state_e;

  localparam logic [31:0] IdValueDefault = 32'h5350_4901;

  function automatic int unsigned frame_bits(input int unsigned ctrl_w,
                                             input int unsigned addr_w,
                                             input int unsigned data_w);
    return ctrl_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_arbiter_if.sv
// Decoder-side and local-side signals of the register arbiter; master drives, slave is the bank.
interface spi_reg_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  spi_cs_n;
  logic [5:0]            spi_shift_cnt;
  logic                  spi_read_en;
  logic [ADDR_WIDTH-1:0] spi_address;
  logic [DATA_WIDTH-1:0] spi_out_data;
  logic [DATA_WIDTH-1:0] spi_rd_data;
  logic                  lcl_req;
  logic                  lcl_we;
  logic [ADDR_WIDTH-1:0] lcl_addr;
  logic [DATA_WIDTH-1:0] lcl_wdata;
  logic                  lcl_gnt;
  logic [DATA_WIDTH-1:0] lcl_rdata;
  logic                  err_addr;

  modport master (
    output spi_cs_n, spi_shift_cnt, spi_read_en, spi_address, spi_out_data,
    output lcl_req, lcl_we, lcl_addr, lcl_wdata,
    input  spi_rd_data, lcl_gnt, lcl_rdata, err_addr
  );

  modport slave (
    input  spi_cs_n, spi_shift_cnt, spi_read_en, spi_address, spi_out_data,
    input  lcl_req, lcl_we, lcl_addr, lcl_wdata,
    output spi_rd_data, lcl_gnt, lcl_rdata, err_addr
  );
endinterface

// File: rtl/spi_frame_tracker.sv
// Follows the decoder bit counter and chip select; flags frame completion, aborts and
// whether the current frame carried a read fetch.
module spi_frame_tracker #(
  parameter int unsigned FRAME_BITS = 48,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                 spi_clk,
  input  logic                 reset_n,
  input  logic                 i_cs_n,
  input  logic [CNT_WIDTH-1:0] i_shift_cnt,
  input  logic                 i_read_en,
  output logic                 o_frame_done,
  output logic                 o_frame_abort,
  output logic                 o_frame_is_read
);

  localparam logic [CNT_WIDTH-1:0] LastBit = CNT_WIDTH'(FRAME_BITS - 1);

  logic [CNT_WIDTH-1:0] r_cnt_prev;
  logic                 r_cs_n_prev;
  logic                 r_frame_is_read;
  logic                 w_frame_is_read_d;

  always_comb begin
    // Counter wrapping from the last bit back to 0 while selected ends a frame.
    o_frame_done  = !i_cs_n && (r_cnt_prev == LastBit) && (i_shift_cnt == '0);
    // Deselect while the counter was still mid-frame.
    o_frame_abort = i_cs_n && !r_cs_n_prev && (r_cnt_prev != '0);
    w_frame_is_read_d = r_frame_is_read;
    if (i_cs_n || o_frame_done) begin
      w_frame_is_read_d = 1'b0;
    end else if (i_read_en) begin
      w_frame_is_read_d = 1'b1;
    end
    o_frame_is_read = r_frame_is_read;
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_prev      <= '0;
      r_cs_n_prev     <= 1'b1;
      r_frame_is_read <= 1'b0;
    end else begin
      r_cnt_prev      <= i_shift_cnt;
      r_cs_n_prev     <= i_cs_n;
      r_frame_is_read <= w_frame_is_read_d;
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Register bank shared by the SPI decoder (zero-stall reads, frame-end writes) and a local
// req/gnt port. Define SPI_ARB_WRITE_PROTECT_EN to make register 0 a read-only ID register.
module spi_reg_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           CTRL_WIDTH = 8,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(IdValueDefault)
) (
  input logic             spi_clk,
  input logic             reset_n,
  spi_reg_arbiter_if.slave bus
);

  localparam int unsigned FrameBits = frame_bits(CTRL_WIDTH, ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned IdxW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef SPI_ARB_WRITE_PROTECT_EN
  localparam bit WriteProtect = 1'b1;
`else
  localparam bit WriteProtect = 1'b0;
`endif

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  function automatic logic is_protected(input logic [ADDR_WIDTH-1:0] a);
    return WriteProtect && (a == '0);
  endfunction

  logic [DATA_WIDTH-1:0] r_bank [NUM_REGS];
  arb_state_e            r_state;
  arb_state_e            w_state_d;
  logic                  r_wr_pending;
  logic                  w_wr_pending_d;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_lcl_gnt;
  logic [DATA_WIDTH-1:0] r_lcl_rdata;
  logic                  r_err_addr;

  logic                  w_frame_done;
  logic                  w_frame_abort;
  logic                  w_frame_is_read;
  logic                  w_commit;
  logic                  w_clr_pending;
  logic                  w_lcl_fire;
  logic                  w_bank_we;
  logic [ADDR_WIDTH-1:0] w_bank_waddr;
  logic [DATA_WIDTH-1:0] w_bank_wdata;
  logic                  w_wr_ok;

  spi_frame_tracker #(
    .FRAME_BITS (FrameBits),
    .CNT_WIDTH  (6)
  ) u_tracker (
    .spi_clk         (spi_clk),
    .reset_n         (reset_n),
    .i_cs_n          (bus.spi_cs_n),
    .i_shift_cnt     (bus.spi_shift_cnt),
    .i_read_en       (bus.spi_read_en),
    .o_frame_done    (w_frame_done),
    .o_frame_abort   (w_frame_abort),
    .o_frame_is_read (w_frame_is_read)
  );

  assign w_commit = w_frame_done && !w_frame_is_read && !w_frame_abort;

  // Decoder samples on the next falling edge, so the read path stays purely combinational.
  assign bus.spi_rd_data = (bus.spi_read_en && in_range(bus.spi_address))
                           ? r_bank[bus.spi_address[IdxW-1:0]] : '0;

  assign bus.lcl_gnt   = r_lcl_gnt;
  assign bus.lcl_rdata = r_lcl_rdata;
  assign bus.err_addr  = r_err_addr;

  always_comb begin
    w_state_d     = r_state;
    w_bank_we     = 1'b0;
    w_bank_waddr  = r_wr_addr;
    w_bank_wdata  = r_wr_data;
    w_lcl_fire    = 1'b0;
    w_clr_pending = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_wr_pending) begin
          w_state_d = StSpiWr;
        end else if (bus.lcl_req && !bus.spi_read_en) begin
          // Local access completes on this edge; StLcl is the grant cycle.
          w_state_d    = StLcl;
          w_lcl_fire   = 1'b1;
          w_bank_we    = bus.lcl_we;
          w_bank_waddr = bus.lcl_addr;
          w_bank_wdata = bus.lcl_wdata;
        end
      end
      StSpiWr: begin
        w_bank_we     = 1'b1;
        w_clr_pending = 1'b1;
        w_state_d     = StIdle;
      end
      StLcl: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign w_wr_ok = in_range(w_bank_waddr) && !is_protected(w_bank_waddr);

  always_comb begin
    w_wr_pending_d = r_wr_pending;
    if (w_clr_pending) begin
      w_wr_pending_d = 1'b0;
    end
    if (w_commit) begin
      w_wr_pending_d = 1'b1;
    end
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_wr_pending <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_lcl_gnt    <= 1'b0;
      r_lcl_rdata  <= '0;
      r_err_addr   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_wr_pending <= w_wr_pending_d;
      if (w_commit) begin
        r_wr_addr <= bus.spi_address;
        r_wr_data <= bus.spi_out_data;
      end
      r_lcl_gnt <= w_lcl_fire;
      if (w_lcl_fire && !bus.lcl_we) begin
        r_lcl_rdata <= in_range(bus.lcl_addr) ? r_bank[bus.lcl_addr[IdxW-1:0]] : '0;
      end
      if (w_bank_we && !w_wr_ok) begin
        r_err_addr <= 1'b1;
      end
    end
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_bank[i] <= (WriteProtect && (i == 0)) ? ID_VALUE : '0;
      end
    end else if (w_bank_we && w_wr_ok) begin
      r_bank[w_bank_waddr[IdxW-1:0]] <= w_bank_wdata;
    end
  end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Randomised scoreboard bench for spi_reg_arbiter; honours SPI_ARB_WRITE_PROTECT_EN.
module tb_spi_reg_arbiter;
  import spi_arb_pkg::*;

  localparam int          AW    = 8;
  localparam int          DW    = 32;
  localparam int          CW    = 8;
  localparam int          NR    = 16;
  localparam int          FB    = CW + AW + DW;
  localparam int          RdBit = CW + AW;
  localparam logic [31:0] IdVal = 32'h5350_4901;
`ifdef SPI_ARB_WRITE_PROTECT_EN
  localparam bit Wp = 1'b1;
`else
  localparam bit Wp = 1'b0;
`endif

  typedef struct packed {
    logic          is_read;
    logic [DW-1:0] data;
  } lcl_exp_t;

  logic spi_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 spi_clk = ~spi_clk;

  spi_reg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi_reg_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .NUM_REGS   (NR),
    .ID_VALUE   (IdVal)
  ) dut (
    .spi_clk (spi_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] model [NR];
  bit            model_err;
  logic [DW-1:0] spi_q [$];
  lcl_exp_t      lcl_q [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writable(input int unsigned a);
    return (a < NR) && !(Wp && a == 0);
  endfunction

  function automatic logic [DW-1:0] mread(input int unsigned a);
    return (a < NR) ? model[a] : '0;
  endfunction

  task automatic mwrite(input int unsigned a, input logic [DW-1:0] d);
    if (writable(a)) model[a] = d;
    else model_err = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = (Wp && i == 0) ? IdVal : '0;
    model_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge spi_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_idle();
    bus.spi_cs_n      = 1'b1;
    bus.spi_shift_cnt = '0;
    bus.spi_read_en   = 1'b0;
    bus.spi_address   = '0;
    bus.spi_out_data  = '0;
    bus.lcl_req       = 1'b0;
    bus.lcl_we        = 1'b0;
    bus.lcl_addr      = '0;
    bus.lcl_wdata     = '0;
  endtask

  // One bit per cycle; abort_bit < 0 runs the frame to completion.
  task automatic spi_frame(input bit is_read, input int unsigned addr, input logic [DW-1:0] data,
                           input int abort_bit);
    bus.spi_cs_n     = 1'b0;
    bus.spi_address  = AW'(addr);
    bus.spi_out_data = is_read ? '0 : data;
    for (int b = 0; b < FB; b++) begin
      bus.spi_shift_cnt = 6'(b);
      if (b == abort_bit) begin
        bus.spi_cs_n      = 1'b1;
        bus.spi_shift_cnt = '0;
        tick();
        return;
      end
      bus.spi_read_en = is_read && (b == RdBit);
      if (bus.spi_read_en) spi_q.push_back(mread(addr));
      tick();
    end
    bus.spi_read_en   = 1'b0;
    bus.spi_shift_cnt = '0;
    check("wr_pending_at_frame_end", 32'(dut.r_wr_pending), '0);
    tick();
    bus.spi_cs_n = 1'b1;
    if (!is_read) mwrite(addr, data);
  endtask

  // lat counts cycles from the request cycle to the grant cycle.
  task automatic lcl_op(input bit we, input int unsigned addr, input logic [DW-1:0] data,
                        output int lat);
    lcl_exp_t e;
    bus.lcl_req   = 1'b1;
    bus.lcl_we    = we;
    bus.lcl_addr  = AW'(addr);
    bus.lcl_wdata = data;
    e.is_read = !we;
    e.data    = we ? '0 : mread(addr);
    lcl_q.push_back(e);
    if (we) mwrite(addr, data);
    lat = 0;
    forever begin
      @(negedge spi_clk);
      if (bus.lcl_gnt) break;
      lat++;
      if (lat > 40) begin
        n_vec++;
        n_bad++;
        $display("FAIL lcl_gnt_timeout: got no grant, want grant within 40 cycles");
        void'(lcl_q.pop_back());
        break;
      end
    end
    @(posedge spi_clk);
    #1;
    bus.lcl_req = 1'b0;
  endtask

  always @(negedge spi_clk) begin : monitor
    lcl_exp_t e;
    if (reset_n) begin
      if (bus.spi_read_en) begin
        if (spi_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spi_rd_unexpected: got read strobe, want none queued");
        end else begin
          check("spi_rd_data", bus.spi_rd_data, spi_q.pop_front());
        end
      end else begin
        check("spi_rd_idle_zero", bus.spi_rd_data, '0);
      end
      if (bus.lcl_gnt) begin
        if (lcl_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL lcl_gnt_unexpected: got grant, want no grant");
        end else begin
          e = lcl_q.pop_front();
          if (e.is_read) check("lcl_rdata", bus.lcl_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int lat2;
    int op;
    int unsigned a;
    drive_idle();
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_lcl_gnt", 32'(bus.lcl_gnt), '0);
    check("reset_err_addr", 32'(bus.err_addr), '0);
    check("reset_lcl_rdata", bus.lcl_rdata, '0);
    check("reset_spi_rd", bus.spi_rd_data, '0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NR; i++) begin
      spi_frame(1'b1, i, '0, -1);
      idle(2);
    end

    // Write lands two edges after frame completion is sampled.
    spi_frame(1'b0, 3, 32'hDEAD_BEEF, -1);
    check("bank3_pending", dut.r_bank[3], '0);
    tick();
    check("bank3_in_spi_wr", dut.r_bank[3], '0);
    tick();
    check("bank3_committed", dut.r_bank[3], 32'hDEAD_BEEF);
    idle(2);
    spi_frame(1'b1, 3, '0, -1);
    idle(2);

    // Local write raised while the SPI commit is pending: SPI first, local wins finally.
    spi_frame(1'b0, 5, 32'h0000_AAAA, -1);
    lcl_op(1'b1, 5, 32'h0000_1234, lat);
    check("lcl_lat_behind_spi_wr", lat, 3);
    idle(2);
    spi_frame(1'b1, 5, '0, -1);
    idle(2);

    // Local read raised in the read-fetch cycle waits one cycle.
    fork
      spi_frame(1'b1, 3, '0, -1);
      begin
        repeat (RdBit) tick();
        lcl_op(1'b0, 5, '0, lat2);
      end
    join
    check("lcl_lat_vs_spi_read", lat2, 2);
    idle(2);

    spi_frame(1'b0, 7, $urandom, 20);
    idle(3);
    check("abort_no_pending", 32'(dut.r_wr_pending), '0);
    check("abort_err_addr", 32'(bus.err_addr), 32'(model_err));
    spi_frame(1'b1, 7, '0, -1);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      a  = $urandom_range(1, NR - 1);
      case (op)
        0: spi_frame(1'b0, a, $urandom, -1);
        1: spi_frame(1'b1, $urandom_range(0, 255), '0, -1);
        2: begin
          lcl_op(1'b1, a, $urandom, lat);
          check("lcl_wr_lat", lat, 1);
        end
        3: begin
          lcl_op(1'b0, $urandom_range(0, 255), '0, lat);
          check("lcl_rd_lat", lat, 1);
        end
        default: spi_frame(1'b0, a, $urandom, $urandom_range(1, FB - 1));
      endcase
      idle(3);
      check("err_addr_track", 32'(bus.err_addr), 32'(model_err));
    end

    lcl_op(1'b1, 200, 32'h0BAD_0BAD, lat);
    idle(2);
    check("err_after_oob_write", 32'(bus.err_addr), 32'(model_err));
    lcl_op(1'b1, 0, 32'h0000_CAFE, lat);
    idle(2);
    spi_frame(1'b0, 0, 32'h0000_BEEF, -1);
    idle(3);
    spi_frame(1'b1, 0, '0, -1);
    idle(2);
    spi_frame(1'b0, 9, 32'h1357_9BDF, -1);
    idle(3);
    check("err_sticky", 32'(bus.err_addr), 32'(model_err));
    spi_frame(1'b1, 9, '0, -1);
    idle(2);

    // Reset with a request in flight: no grant, everything back to reset values.
    bus.lcl_req  = 1'b1;
    bus.lcl_we   = 1'b0;
    bus.lcl_addr = AW'(3);
    #2 reset_n = 1'b0;
    repeat (3) begin
      @(negedge spi_clk);
      check("gnt_in_reset", 32'(bus.lcl_gnt), '0);
    end
    bus.lcl_req = 1'b0;
    model_reset();
    check("err_cleared_by_reset", 32'(bus.err_addr), '0);
    @(posedge spi_clk);
    #1 reset_n = 1'b1;
    tick();
    spi_frame(1'b1, 3, '0, -1);
    idle(2);
    spi_frame(1'b1, 0, '0, -1);
    idle(3);
    check("spi_q_drained", 32'(spi_q.size()), '0);
    check("lcl_q_drained", 32'(lcl_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
